// File: rtl/fmul_arbiter.sv
// fmul_arbiter: round-robin sharing of one pipelined fp32 multiplier among NREQ requesters
module fmul (
  input  logic        clk,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y
);
  logic               s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, g, st, rnd;
  logic [7:0]         ea, eb;
  logic [47:0]        p;
  logic [22:0]        mant;
  logic [23:0]        mr;
  logic signed [10:0] e;
  logic [31:0]        prod;
  // fp32 product, round-to-nearest-even, subnormal inputs and results flushed to zero
  always_comb begin
    s = x1[31] ^ x2[31];
    ea = x1[30:23];
    eb = x2[30:23];
    a_nan = ea == 8'hff && x1[22:0] != 23'd0;
    b_nan = eb == 8'hff && x2[22:0] != 23'd0;
    a_inf = ea == 8'hff && x1[22:0] == 23'd0;
    b_inf = eb == 8'hff && x2[22:0] == 23'd0;
    a_zero = ea == 8'd0;
    b_zero = eb == 8'd0;
    p = {24'd0, 1'b1, x1[22:0]} * {24'd0, 1'b1, x2[22:0]};
    mant = p[47] ? p[46:24] : p[45:23];
    g = p[47] ? p[23] : p[22];
    st = p[47] ? |p[22:0] : |p[21:0];
    rnd = g & (st | mant[0]);
    mr = {1'b0, mant} + {23'd0, rnd};
    e = $signed({3'd0, ea}) + $signed({3'd0, eb}) - 11'sd127 + $signed({10'd0, p[47]}) + $signed({10'd0, mr[23]});
    prod = (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) ? 32'h7fc00000 :
           (a_inf || b_inf) ? {s, 8'hff, 23'd0} :
           (a_zero || b_zero) ? {s, 31'd0} :
           (e >= 11'sd255) ? {s, 8'hff, 23'd0} :
           (e <= 11'sd0) ? {s, 31'd0} : {s, e[7:0], mr[22:0]};
  end
  // single pipeline register, intentionally unreset
  always_ff @(posedge clk) y <= prod;
endmodule

module fmul_arbiter #(
  parameter int NREQ = 4,
  parameter int TW = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_x1,
  input  logic [32*NREQ-1:0]   req_x2,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [32*NREQ-1:0]   rsp_y,
  output logic                 busy
);
  logic          s1_v, s2_v, found;
  logic [TW-1:0] s1_tag, s2_tag, last, win;
  logic [31:0]   s1_x1, s1_x2, y;
  logic [31:0]   rsp_d [NREQ];
  logic [NREQ-1:0] inflight, elig;

  fmul u_fmul (.clk(clk), .x1(s1_x1), .x2(s1_x2), .y(y));

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign rsp_y[32*g +: 32] = rsp_d[g];
  end

  // a requester stays ineligible from accept until its response slot drains
  always_comb begin
    for (int i = 0; i < NREQ; i++)
      inflight[i] = (s1_v && s1_tag == TW'(i)) || (s2_v && s2_tag == TW'(i)) || rsp_valid[i];
    elig = req_valid & ~inflight;
  end

  // round-robin search: indices above last beat indices at or below it, lowest first in each group
  always_comb begin
    found = 1'b0;
    win = last;
    for (int i = NREQ - 1; i >= 0; i--)
      if (elig[i] && i <= int'(last)) begin
        found = 1'b1;
        win = TW'(i);
      end
    for (int i = NREQ - 1; i >= 0; i--)
      if (elig[i] && i > int'(last)) begin
        found = 1'b1;
        win = TW'(i);
      end
  end

  // grant and activity outputs, forced idle while reset is held
  always_comb begin
    req_ready = (rstn && found) ? (NREQ'(1) << win) : '0;
    busy = rstn && (s1_v || s2_v || |rsp_valid);
  end

  // issue stage and owner tracking alongside the fmul register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s1_tag <= '0;
      s2_tag <= '0;
      last <= TW'(NREQ - 1);
    end else begin
      s1_v <= found;
      s2_v <= s1_v;
      s2_tag <= s1_tag;
      if (found) begin
        s1_tag <= win;
        s1_x1 <= req_x1[32*win +: 32];
        s1_x2 <= req_x2[32*win +: 32];
        last <= win;
      end
    end
  end

  // per-requester response slots hold a product until accepted
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++)
      if (!rstn) begin
        rsp_valid[i] <= 1'b0;
        rsp_d[i] <= '0;
      end else if (s2_v && s2_tag == TW'(i)) begin
        rsp_valid[i] <= 1'b1;
        rsp_d[i] <= y;
      end else if (rsp_ready[i]) begin
        rsp_valid[i] <= 1'b0;
      end
  end
endmodule

// File: tb/tb_fmul_arbiter.sv
// tb_fmul_arbiter: directed bench with per-requester scoreboard for fmul_arbiter
module tb_fmul_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [N-1:0] req_valid = '1;
  logic [N-1:0] rsp_ready = '1;
  logic [N-1:0] req_ready, rsp_valid;
  logic [32*N-1:0] req_x1 = '0;
  logic [32*N-1:0] req_x2 = '0;
  logic [32*N-1:0] rsp_y;
  logic busy;
  logic [31:0] exp_y [N];
  logic [31:0] exp_q [N][$];
  logic [N-1:0] seen = '0;
  int acc_who[$], acc_when[$], rsp_who[$], rsp_when[$];
  int cyc = 0, tests = 0, fails = 0, n3 = 0;

  always #5 clk = ~clk;

  fmul_arbiter #(.NREQ(N)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_x1(req_x1), .req_x2(req_x2), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .busy(busy)
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int i, logic [31:0] a, logic [31:0] b, logic [31:0] e);
    req_x1[32*i +: 32] = a;
    req_x2[32*i +: 32] = b;
    exp_y[i] = e;
  endtask

  task automatic clear_logs();
    acc_who.delete();
    acc_when.delete();
    rsp_who.delete();
    rsp_when.delete();
  endtask

  // mid-cycle monitor: handshakes push expectations, first sight of a response pops and compares
  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      for (int i = 0; i < N; i++) exp_q[i].delete();
      seen = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_q[i].push_back(exp_y[i]);
          acc_who.push_back(i);
          acc_when.push_back(cyc);
        end
        if (rsp_valid[i] && !seen[i]) begin
          seen[i] = 1'b1;
          rsp_who.push_back(i);
          rsp_when.push_back(cyc);
          if (exp_q[i].size() == 0) check("rsp_unexpected", {31'd0, rsp_valid[i]}, 32'd0);
          else check("rsp_y", rsp_y[32*i +: 32], exp_q[i].pop_front());
        end
        if (rsp_valid[i] && rsp_ready[i]) seen[i] = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) exp_y[i] = '0;
    repeat (3) nxt();
    #1;
    check("rst_req_ready", {28'd0, req_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
    check("rst_rsp_y_zero", {31'd0, rsp_y == '0}, 32'd1);
    // single op
    nxt();
    rstn = 1'b1;
    req_valid = 4'b0001;
    rsp_ready = 4'b0000;
    drive(0, 32'h40000000, 32'h40400000, 32'h40C00000);
    #1;
    check("single_grant", {28'd0, req_ready}, 32'b0001);
    nxt();
    req_valid = '0;
    #1;
    check("single_s1_ready", {28'd0, req_ready}, 32'd0);
    check("single_s1_busy", {31'd0, busy}, 32'd1);
    check("single_s1_rsp", {28'd0, rsp_valid}, 32'd0);
    nxt();
    check("single_s2_rsp", {28'd0, rsp_valid}, 32'd0);
    nxt();
    check("single_rsp_valid", {28'd0, rsp_valid}, 32'b0001);
    check("single_rsp_y", rsp_y[31:0], 32'h40C00000);
    rsp_ready = 4'b0001;
    #1;
    check("single_busy_held", {31'd0, busy}, 32'd1);
    nxt();
    check("single_busy_done", {31'd0, busy}, 32'd0);
    check("single_drained", {28'd0, rsp_valid}, 32'd0);
    // full contention from the first post-reset cycle, slot 0 held
    rstn = 1'b0;
    nxt();
    nxt();
    clear_logs();
    rstn = 1'b1;
    rsp_ready = 4'b1110;
    for (int i = 0; i < N; i++) drive(i, 32'hBF800000, 32'h40000000, 32'hC0000000);
    req_valid = 4'b1111;
    #1;
    check("cont_grant0", {28'd0, req_ready}, 32'b0001);
    nxt();
    check("cont_grant1", {28'd0, req_ready}, 32'b0010);
    nxt();
    check("cont_grant2", {28'd0, req_ready}, 32'b0100);
    nxt();
    check("cont_grant3", {28'd0, req_ready}, 32'b1000);
    nxt();
    req_valid = 4'b0001;
    #1;
    check("cont_hold_ready", {28'd0, req_ready}, 32'd0);
    check("cont_hold_valid0", {31'd0, rsp_valid[0]}, 32'd1);
    nxt();
    check("cont_hold_ready2", {28'd0, req_ready}, 32'd0);
    rsp_ready = 4'b1111;
    nxt();
    check("cont_drained0", {31'd0, rsp_valid[0]}, 32'd0);
    check("cont_regrant0", {28'd0, req_ready}, 32'b0001);
    nxt();
    req_valid = '0;
    repeat (5) nxt();
    check("cont_nacc", acc_who.size(), 32'd5);
    check("cont_nrsp", rsp_who.size(), 32'd5);
    if (acc_who.size() >= 5 && rsp_who.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        check("cont_acc_order", acc_who[k], k);
        check("cont_acc_gap", acc_when[k] - acc_when[0], k);
        check("cont_rsp_order", rsp_who[k], k);
        check("cont_latency", rsp_when[k] - acc_when[k], 32'd3);
      end
      check("cont_acc5", acc_who[4], 32'd0);
    end
    // fairness between requesters 0 and 2
    clear_logs();
    drive(0, 32'h3F800000, 32'h40A00000, 32'h40A00000);
    drive(2, 32'h40000000, 32'h40800000, 32'h41000000);
    req_valid = 4'b0101;
    repeat (12) nxt();
    req_valid = '0;
    repeat (5) nxt();
    check("fair_enough", {31'd0, acc_who.size() >= 4}, 32'd1);
    if (acc_who.size() >= 1) check("fair_first", acc_who[0], 32'd2);
    for (int k = 1; k < acc_who.size(); k++) check("fair_alternate", {31'd0, acc_who[k] != acc_who[k-1]}, 32'd1);
    // backpressure on requester 1 while requester 3 keeps going
    clear_logs();
    rsp_ready = 4'b1101;
    drive(1, 32'h00000000, 32'h40400000, 32'h00000000);
    drive(3, 32'h3FC00000, 32'h40000000, 32'h40400000);
    req_valid = 4'b1010;
    repeat (4) nxt();
    check("bp_valid_set", {31'd0, rsp_valid[1]}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      nxt();
      check("bp_valid_stable", {31'd0, rsp_valid[1]}, 32'd1);
      check("bp_y_stable", rsp_y[63:32], 32'h00000000);
      check("bp_no_grant1", {31'd0, req_ready[1]}, 32'd0);
    end
    n3 = 0;
    foreach (acc_who[k]) if (acc_who[k] == 3) n3++;
    check("bp_req3_progress", {31'd0, n3 >= 3}, 32'd1);
    req_valid = '0;
    rsp_ready = 4'b1111;
    repeat (5) nxt();
    check("bp_drained", {28'd0, rsp_valid}, 32'd0);
    // reset one cycle after accepting from 0 and 1
    clear_logs();
    drive(0, 32'h40000000, 32'h40400000, 32'h40C00000);
    drive(1, 32'hBF800000, 32'h40000000, 32'hC0000000);
    req_valid = 4'b0011;
    nxt();
    nxt();
    req_valid = '0;
    rstn = 1'b0;
    check("mid_accepts", acc_who.size(), 32'd2);
    nxt();
    rstn = 1'b1;
    #1;
    check("mid_rsp_valid", {28'd0, rsp_valid}, 32'd0);
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_rsp_y_zero", {31'd0, rsp_y == '0}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      nxt();
      check("mid_no_stale", {28'd0, rsp_valid}, 32'd0);
    end
    drive(1, 32'h3FC00000, 32'h3FC00000, 32'h40100000);
    req_valid = 4'b0010;
    #1;
    check("mid_grant1", {28'd0, req_ready}, 32'b0010);
    nxt();
    req_valid = '0;
    nxt();
    nxt();
    check("mid_rsp1_valid", {28'd0, rsp_valid}, 32'b0010);
    check("mid_rsp1_y", rsp_y[63:32], 32'h40100000);
    repeat (3) nxt();
    // wrap-around: park last on 3, then 1 and 3 together
    drive(3, 32'h40800000, 32'h40800000, 32'h41800000);
    req_valid = 4'b1000;
    nxt();
    req_valid = '0;
    repeat (4) nxt();
    clear_logs();
    drive(1, 32'hC0000000, 32'h40400000, 32'hC0C00000);
    drive(3, 32'h3F000000, 32'h40000000, 32'h3F800000);
    req_valid = 4'b1010;
    #1;
    check("wrap_first", {28'd0, req_ready}, 32'b0010);
    nxt();
    check("wrap_second", {28'd0, req_ready}, 32'b1000);
    nxt();
    req_valid = '0;
    repeat (5) nxt();
    check("wrap_nacc", acc_who.size(), 32'd2);
    if (acc_who.size() >= 2) begin
      check("wrap_order0", acc_who[0], 32'd1);
      check("wrap_order1", acc_who[1], 32'd3);
    end
    for (int i = 0; i < N; i++) check("sb_drained", exp_q[i].size(), 32'd0);
    check("end_busy", {31'd0, busy}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
